// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences radix-2 Booth multiply and signed restoring divide
// through one shared external 33-bit adder, one iteration per cycle.
module multdiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [32:0] add_a,
  output logic [32:0] add_b,
  output logic        add_cin,
  input  logic [32:0] add_sum
);
  typedef enum logic [2:0] {IDLE, MULT, NEG_A, NEG_B, DIV, FIX, DONE} state_t;
  state_t      r_state, w_nxt;
  logic [32:0] r_hi, r_m;
  logic [31:0] r_lo, r_result;
  logic [5:0]  r_cnt;
  logic        r_qb, r_sa, r_sb, r_exc, r_busy;
  logic        w_go_m, w_go_d, w_dz, w_last, w_neg;
  logic [31:0] w_plo;
  logic [32:0] w_phi;
  assign w_go_m = ctrl_MULT;
  assign w_go_d = ctrl_DIV & ~ctrl_MULT;
  assign w_dz   = w_go_d & (data_operandB == 32'd0);
  assign w_last = r_cnt == 6'(ITER - 1);
  assign w_neg  = r_sa ^ r_sb;
  // product after the final Booth shift, needed on the edge that enters DONE
  assign w_plo  = {add_sum[0], r_lo[31:1]};
  assign w_phi  = {add_sum[32], add_sum[32:1]};
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != IDLE) & ~w_dz;
    end
  end
  always_comb begin
    w_nxt = IDLE;
    case (r_state)
      MULT:    w_nxt = w_last ? DONE : MULT;
      NEG_A:   w_nxt = NEG_B;
      NEG_B:   w_nxt = DIV;
      DIV:     w_nxt = w_last ? FIX : DIV;
      FIX:     w_nxt = DONE;
      default: w_nxt = IDLE;
    endcase
    if (w_go_d) w_nxt = w_dz ? DONE : NEG_A;
    if (w_go_m) w_nxt = MULT;
  end
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (r_state)
      MULT: begin
        add_a   = r_hi;
        add_b   = (r_lo[0] ^ r_qb) ? (r_qb ? r_m : ~r_m) : '0;
        add_cin = r_lo[0] & ~r_qb;
      end
      NEG_A, FIX: begin
        add_a   = {1'b0, ~r_lo};
        add_cin = 1'b1;
      end
      NEG_B: begin
        add_a   = {1'b0, ~r_m[31:0]};
        add_cin = 1'b1;
      end
      DIV: begin
        add_a   = {r_hi[31:0], r_lo[31]};
        add_b   = ~{1'b0, r_m[31:0]};
        add_cin = 1'b1;
      end
      default: ;
    endcase
    data_resultRDY = r_state == DONE;
    busy           = r_busy;
    data_result    = r_result;
    data_exception = r_exc;
  end
  // divide reuses r_hi as remainder, r_lo as dividend/quotient, r_m as |divisor|
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_qb     <= 1'b0;
      r_m      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_cnt    <= '0;
      r_exc    <= 1'b0;
      r_result <= '0;
    end else if (w_go_m | w_go_d) begin
      r_hi  <= '0;
      r_lo  <= data_operandA;
      r_qb  <= 1'b0;
      r_m   <= {data_operandB[31], data_operandB};
      r_sa  <= data_operandA[31];
      r_sb  <= data_operandB[31];
      r_cnt <= '0;
      r_exc <= w_dz;
      if (w_dz) r_result <= '0;
    end else begin
      case (r_state)
        MULT: begin
          {r_hi, r_lo, r_qb} <= {add_sum[32], add_sum, r_lo};
          r_cnt <= w_last ? r_cnt : r_cnt + 6'd1;
          if (w_last) begin
            r_result <= w_plo;
            r_exc    <= w_phi != {33{w_plo[31]}};
          end
        end
        NEG_A: r_lo <= r_sa ? add_sum[31:0] : r_lo;
        NEG_B: r_m <= {1'b0, r_sb ? add_sum[31:0] : r_m[31:0]};
        DIV: begin
          r_hi  <= add_sum[32] ? {r_hi[31:0], r_lo[31]} : add_sum;
          r_lo  <= {r_lo[30:0], ~add_sum[32]};
          r_cnt <= w_last ? r_cnt : r_cnt + 6'd1;
        end
        FIX: begin
          r_result <= w_neg ? add_sum[31:0] : r_lo;
          r_exc    <= ~w_neg & r_lo[31];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed vector table plus abort and reset sequences for multdiv_ctrl,
// with the shared adder modelled in the bench.
module tb_multdiv_ctrl;
  logic        clock = 1'b0, reset_n = 1'b0, ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy, add_cin;
  logic [32:0] add_a, add_b, add_sum;
  int          total = 0, bad = 0;
  logic [31:0] prev_res = '0;
  typedef struct {
    logic        m, d;
    logic [31:0] a, b, res;
    logic        exc;
    int          lat;
    logic        bz;
  } vec_t;
  vec_t tv[13];
  multdiv_ctrl dut (
    .clock(clock), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
  );
  always #5 clock = ~clock;
  assign add_sum = add_a + add_b + {32'd0, add_cin};
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, "_adda"}, add_a, 0);
    chk({nm, "_addb"}, add_b, 0);
    chk({nm, "_cin"}, add_cin, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rdy"}, data_resultRDY, 0);
  endtask
  task automatic run_op(input vec_t v, input int idx);
    int          rdy_at = 0, rdys = 0, busy_err = 0;
    logic [31:0] res = '0;
    logic        exc = 1'b0;
    ctrl_MULT = v.m;
    ctrl_DIV = v.d;
    data_operandA = v.a;
    data_operandB = v.b;
    tick;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    if (v.lat > 1) begin
      chk($sformatf("v%0d_exc_clr", idx), data_exception, 0);
      chk($sformatf("v%0d_hold", idx), data_result, prev_res);
    end
    for (int k = 1; k <= 45; k++) begin
      if (data_resultRDY) begin
        rdys++;
        if (rdy_at == 0) begin
          rdy_at = k;
          res = data_result;
          exc = data_exception;
        end
      end
      if (busy !== (v.bz && k <= v.lat)) busy_err++;
      tick;
    end
    chk($sformatf("v%0d_res", idx), res, v.res);
    chk($sformatf("v%0d_exc", idx), exc, v.exc);
    chk($sformatf("v%0d_lat", idx), rdy_at, v.lat);
    chk($sformatf("v%0d_rdys", idx), rdys, 1);
    chk($sformatf("v%0d_busy_err", idx), busy_err, 0);
    chk($sformatf("v%0d_res_hold", idx), data_result, v.res);
    chk_idle($sformatf("v%0d_idle", idx));
    prev_res = v.res;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int          rdys, rdy_at;
    logic [31:0] res;
    tv[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 1'b1};
    tv[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33, 1'b1};
    tv[2]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33, 1'b1};
    tv[3]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       1'b0, 33, 1'b1};
    tv[5]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 36, 1'b1};
    tv[6]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0, 36, 1'b1};
    tv[7]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 36, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1, 1,  1'b0};
    tv[9]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0, 36, 1'b1};
    tv[10] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, 36, 1'b1};
    tv[11] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFF9C, 32'd0,        1'b0, 36, 1'b1};
    tv[12] = '{1'b1, 1'b1, 32'd6,        32'd7,        32'd42,       1'b0, 33, 1'b1};
    tick;
    tick;
    chk("rst_result", data_result, 0);
    chk("rst_exc", data_exception, 0);
    chk_idle("rst");
    reset_n = 1'b1;
    tick;
    for (int i = 0; i < 13; i++) run_op(tv[i], i);
    // abort: divide started, then a multiply arrives ten cycles later
    rdys = 0;
    rdy_at = 0;
    res = '0;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    tick;
    ctrl_DIV = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (data_resultRDY) begin
        rdys++;
        if (rdy_at == 0) begin
          rdy_at = k;
          res = data_result;
        end
      end
      ctrl_MULT = k == 10;
      if (k == 10) begin
        data_operandA = 32'd6;
        data_operandB = 32'd7;
      end
      tick;
    end
    chk("abort_rdys", rdys, 1);
    chk("abort_lat", rdy_at, 43);
    chk("abort_res", res, 42);
    prev_res = 32'd42;
    // reset in the middle of a multiply, with a start pulse during reset
    rdys = 0;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    tick;
    ctrl_MULT = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k >= 21 && data_resultRDY) rdys++;
      if (k == 21) begin
        chk("mid_rst_result", data_result, 0);
        chk("mid_rst_exc", data_exception, 0);
        chk_idle("mid_rst");
      end
      if (k == 20) begin
        reset_n = 1'b0;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
      end else if (k == 21) begin
        reset_n = 1'b1;
        ctrl_MULT = 1'b0;
      end
      tick;
    end
    chk("mid_rst_rdys", rdys, 0);
    chk("post_rst_busy", busy, 0);
    prev_res = '0;
    run_op('{1'b1, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 33, 1'b1}, 99);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller for the multiplier/divider unit. It takes single-cycle multiply or divide requests and runs each one as a multi-cycle iteration through one shared external 33-bit carry-lookahead adder. Multiply uses radix-2 Booth; divide uses signed restoring division on operand magnitudes. It returns a 32-bit result, an exception flag and a one-cycle ready pulse to the pipeline's multdiv stage.

## Interface
Parameters:
- ITER, 32, iteration count for both operations; fixed at 32 for a 32-bit datapath.

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- ctrl_MULT  in  1  one-cycle multiply start pulse
- ctrl_DIV  in  1  one-cycle divide start pulse
- data_operandA  in  32  multiplicand / dividend (signed); sampled on the start edge
- data_operandB  in  32  multiplier / divisor (signed); sampled on the start edge
- data_result  out  32  product low word or quotient
- data_exception  out  1  overflow or divide-by-zero; valid while data_resultRDY=1
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high while an operation is in flight
- add_a  out  33  shared adder operand A
- add_b  out  33  shared adder operand B
- add_cin  out  1  shared adder carry-in
- add_sum  in  33  shared adder sum, combinational in the same cycle

## Operation
- States: IDLE, MULT, NEG_A, NEG_B, DIV, FIX, DONE.
- Start handling: t0 is the edge that samples a start pulse.
  - Start pulses are accepted in any state. A start in a non-IDLE state aborts the op in flight with no RDY for it.
  - ctrl_MULT and ctrl_DIV together: MULT wins.
  - Starts while reset_n=0 are ignored.
- Adder usage in IDLE/DONE: drive add_a=0, add_b=0, add_cin=0.
- MULT:
  - Registers: P_hi (33b, initialized to 0), P_lo=A, q=0, M={B[31],B}.
  - Each iteration looks at {P_lo[0],q}:
    - 01: add_a=P_hi, add_b=M, cin=0.
    - 10: add_a=P_hi, add_b=~M, cin=1.
    - 00/11: add_b=0, cin=0.
  - Then arithmetic right shift of {add_sum,P_lo,q} by 1.
  - After 32 iterations: result=P_lo. exception=1 unless every bit of P_hi equals P_lo[31].
- DIV:
  - If B==0 at t0: go directly to DONE with result=0, exception=1.
  - Otherwise record sA=A[31], sB=B[31].
  - NEG_A: if sA, |A| = ~A+1 via adder (a={0,~A}, b=0, cin=1); otherwise pass A through.
  - NEG_B: same for B.
  - 32 iterations:
    - R' = {R[31:0], Q[31]}.
    - Adder computes R' + ~{0,|B|} + 1.
    - If add_sum[32]==0: R=add_sum, shift 1 into Q. Otherwise R=R', shift 0 into Q.
  - FIX: if sA^sB, result=~Q+1 via adder. Otherwise result=Q, and exception=1 if Q[31]=1 (only case: 0x80000000 / -1, result 0x80000000).
  - Quotient truncates toward zero; remainder is discarded.
- DONE (one cycle):
  - data_resultRDY=1; data_result and data_exception updated.
  - Then IDLE, or the new op if a start arrives in that cycle.
- Output holding: data_result holds its value until the next completion. data_exception is cleared on the next start.

## Timing
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, busy=0, state=IDLE, add_* all 0.
- busy rises in the cycle after t0 and falls in the DONE cycle.
- MULT: iterations occupy t0+1..t0+32; data_resultRDY is high in cycle t0+33.
- DIV:
  - NEG_A at t0+1, NEG_B at t0+2, iterations t0+3..t0+34, FIX at t0+35.
  - data_resultRDY is high in cycle t0+36.
- DIV by zero: data_resultRDY is high in cycle t0+1.
- data_resultRDY is exactly one cycle wide and never asserts for an aborted op.
- Reset asserted mid-op: at the next edge, go to IDLE with reset output values; no RDY.
- Iteration counter: 6-bit, counts 0..31, no wrap beyond terminal count.

## Test plan
- MULT 7 × -3 -> data_result=0xFFFFFFEB, exception=0, RDY only at t0+33; busy high t0+1..t0+33.
- MULT corner cases:
  - 0x00010000 × 0x00010000 -> result 0x00000000, exception=1.
  - 0x80000000 × 1 -> 0x80000000, exception=0.
  - 0x80000000 × 0xFFFFFFFF -> exception=1.
- DIV signed cases, each with RDY at t0+36:
  - -7 / 2 -> 0xFFFFFFFD, exception=0.
  - 100 / -10 -> 0xFFFFFFF6.
  - 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception=1.
- DIV 5 / 0 -> RDY at t0+1, result 0, exception=1; busy never asserted.
- Abort: ctrl_DIV at t0, ctrl_MULT (6×7) at t0+10 -> single RDY at t0+43 with result 42; simultaneous ctrl_MULT+ctrl_DIV -> multiply result.
- Reset: reset_n=0 at t0+20 of a MULT -> all outputs 0 next cycle, no RDY in t0+21..t0+40; a start after reset release completes normally.
